pakout_arbiter: RTL

Round-robin arbiter that shares one outbound message channel among NCH source channels. All channels use the codebase four-phase req/ack message handshake. The arbiter latches the winning message, acks the source, and forwards the message on the output channel. It sits between several message producers (e.g. multiple SRC blocks in pakout_io-style designs) and a single pakout/packet sink.

---
 rtl/pakout_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pakout_arbiter.sv
// pakout_arbiter: round-robin arbiter sharing one outbound four-phase req/ack message channel
// among NCH source channels. The winning message is latched and forwarded. The source ack and
// the sink handshake then run independently until both have returned to zero.
//
// Ports:
//   i_clk        clock, all logic on posedge
//   reset        synchronous active-high reset
//   i_req[NCH]   per-source request
//   i_msg        per-source message, channel k at [k*MSZ +: MSZ], packed {red, dat, dst, src}
//   i_ack[NCH]   per-source ack
//   o_req/o_ack  outbound handshake
//   o_src/o_dst/o_dat/o_red  latched outbound message fields
//   o_busy       high while a transfer is in progress
//   o_cnt        completed outbound handshakes, wraps at 16 bits
module pakout_arbiter #(
    parameter int unsigned NCH = 4,
    parameter int unsigned ASZ = 6,
    parameter int unsigned DSZ = 4,
    parameter int unsigned RSZ = 4,
    localparam int unsigned MSZ = 2 * ASZ + DSZ + RSZ
) (
    input  logic               i_clk,
    input  logic               reset,
    input  logic [NCH-1:0]     i_req,
    input  logic [NCH*MSZ-1:0] i_msg,
    output logic [NCH-1:0]     i_ack,
    output logic               o_req,
    input  logic               o_ack,
    output logic [ASZ-1:0]     o_src,
    output logic [ASZ-1:0]     o_dst,
    output logic [DSZ-1:0]     o_dat,
    output logic [RSZ-1:0]     o_red,
    output logic               o_busy,
    output logic [15:0]        o_cnt
);

    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {
        StIdle,
        StXfer
    } state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  win_q, win_d;
    logic [MSZ-1:0] msg_q, msg_d;
    logic [NCH-1:0] ack_q, ack_d;
    logic           oreq_q, oreq_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           in_fin_q, in_fin_d;
    logic           out_fin_q, out_fin_d;

    // Round-robin search starting at ptr; sum is one bit wider so the mod-NCH wrap is explicit.
    logic           grant_vld;
    logic [PW-1:0]  grant_idx;
    logic [PW:0]    sum;
    logic [MSZ-1:0] grant_msg;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        sum       = '0;
        for (int i = 0; i < NCH; i++) begin
            sum = {1'b0, ptr_q} + (PW + 1)'(i);
            if (sum >= (PW + 1)'(NCH)) begin
                sum = sum - (PW + 1)'(NCH);
            end
            if (!grant_vld && i_req[sum[PW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = sum[PW-1:0];
            end
        end
    end

    always_comb begin
        grant_msg = '0;
        for (int k = 0; k < NCH; k++) begin
            if (grant_idx == PW'(k)) begin
                grant_msg = i_msg[k*MSZ +: MSZ];
            end
        end
    end

    logic in_done;
    logic out_done;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        msg_d     = msg_q;
        ack_d     = ack_q;
        oreq_d    = oreq_q;
        cnt_d     = cnt_q;
        in_fin_d  = in_fin_q;
        out_fin_d = out_fin_q;
        in_done   = in_fin_q;
        out_done  = out_fin_q;

        unique case (state_q)
            StIdle: begin
                // A sink still holding ack from the last transfer blocks the next grant.
                if (grant_vld && !o_ack) begin
                    msg_d            = grant_msg;
                    win_d            = grant_idx;
                    ptr_d            = (grant_idx == PW'(NCH - 1)) ? '0 : grant_idx + PW'(1);
                    ack_d            = '0;
                    ack_d[grant_idx] = 1'b1;
                    oreq_d           = 1'b1;
                    in_fin_d         = 1'b0;
                    out_fin_d        = 1'b0;
                    state_d          = StXfer;
                end
            end
            StXfer: begin
                if (ack_q[win_q] && !i_req[win_q]) begin
                    ack_d[win_q] = 1'b0;
                    in_fin_d     = 1'b1;
                    in_done      = 1'b1;
                end
                if (oreq_q && o_ack) begin
                    oreq_d = 1'b0;
                    cnt_d  = cnt_q + 16'd1;
                end
                // o_req low inside XFER means the sink has already acked once.
                if (!oreq_q && !o_ack && !out_fin_q) begin
                    out_fin_d = 1'b1;
                    out_done  = 1'b1;
                end
                if (in_done && out_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            win_q     <= '0;
            msg_q     <= '0;
            ack_q     <= '0;
            oreq_q    <= 1'b0;
            cnt_q     <= '0;
            in_fin_q  <= 1'b0;
            out_fin_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            msg_q     <= msg_d;
            ack_q     <= ack_d;
            oreq_q    <= oreq_d;
            cnt_q     <= cnt_d;
            in_fin_q  <= in_fin_d;
            out_fin_q <= out_fin_d;
        end
    end

    assign i_ack                        = ack_q;
    assign o_req                        = oreq_q;
    assign {o_red, o_dat, o_dst, o_src} = msg_q;
    assign o_busy                       = (state_q != StIdle);
    assign o_cnt                        = cnt_q;

endmodule
